// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring-divide step per cycle, 32 steps per operation.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] move_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] work;

  logic        sgn_op;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [32:0] sum;
  logic [32:0] trial;
  logic [63:0] work_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // work holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sgn_op   = ~op[0];
    mag_rs   = (sgn_op && rs_data[31]) ? -rs_data : rs_data;
    mag_rt   = (sgn_op && rt_data[31]) ? -rt_data : rt_data;
    sum      = {1'b0, work[63:32]} + {1'b0, (work[0] ? opnd : 32'd0)};
    trial    = work[63:31] - {1'b0, opnd};
    work_nxt = {sum, work[31:1]};
    if (is_div) begin
      work_nxt = trial[32] ? {work[62:0], 1'b0} : {trial[31:0], work[30:0], 1'b1};
    end
    prod_fix = (neg_a ^ neg_b) ? -work_nxt : work_nxt;
    quo_fix  = (neg_a ^ neg_b) ? -work_nxt[31:0] : work_nxt[31:0];
    rem_fix  = neg_a ? -work_nxt[63:32] : work_nxt[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            cnt         <= 5'd0;
            div_by_zero <= 1'b0;
            is_div      <= op[1];
            neg_a       <= sgn_op & rs_data[31];
            neg_b       <= sgn_op & rt_data[31];
            opnd        <= op[1] ? mag_rt : mag_rs;
            work        <= {32'd0, (op[1] ? mag_rs : mag_rt)};
          end else begin
            if (hi_we) hi <= move_data;
            if (lo_we) lo <= move_data;
          end
        end
        RUN: begin
          work <= work_nxt;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (opnd == 32'd0) begin
              // a zero divisor shifts the whole dividend into the remainder
              hi          <= rem_fix;
              lo          <= 32'hFFFF_FFFF;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          if (hi_we) hi <= move_data;
          if (lo_we) lo <= move_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Each scenario task drives stimulus and checks results against hand-computed values.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] move_data = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .move_data(move_data), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Issues one operation from a point after a falling edge; returns at the falling edge after done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dbz,
                        output logic dbz_first, output int busy_cnt, output logic got_done,
                        output logic done_next);
    bit first;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clock);
    #1 start = 1'b0; rs_data = 32'h0BAD_0BAD; rt_data = 32'h0DEA_D000;
    busy_cnt = 0; got_done = 1'b0; first = 1'b1; dbz_first = 1'b1;
    r_hi = 32'd0; r_lo = 32'd0; r_dbz = 1'b0; done_next = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (first) dbz_first = div_by_zero;
      first = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    r_hi = hi; r_lo = lo; r_dbz = div_by_zero;
    @(negedge clock);
    done_next = done;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; move_data = 32'hFFFF_0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b dbz=%b required 0", busy, done, div_by_zero);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_multu_max;
    logic [31:0] h, l; logic z, zf, gd, dn; int bc;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, z, zf, bc, gd, dn);
    checks++;
    if (!gd) begin errors++; $display("FAIL multu_timeout: done never seen"); end
    checks++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_max: hi=%h lo=%h required fffffffe/00000001", h, l);
    end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL multu_busy_len: got %0d required 32", bc); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL multu_done_width: done=%b one cycle later, required 0", dn); end
  endtask

  task automatic test_mult_signed;
    logic [31:0] h, l; logic z, zf, gd, dn; int bc;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_neg: hi=%h lo=%h required ffffffff/ffffffeb", h, l);
    end
    run_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'h0000_0000 || l !== 32'h0000_002A) begin
      errors++; $display("FAIL mult_negneg: hi=%h lo=%h required 00000000/0000002a", h, l);
    end
  endtask

  task automatic test_div_signed;
    logic [31:0] h, l; logic z, zf, gd, dn; int bc;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg: hi=%h lo=%h required ffffffff/fffffffd", h, l);
    end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL div_busy_len: got %0d required 32", bc); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'h0000_0000 || l !== 32'h8000_0000 || z !== 1'b0) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h dbz=%b required 00000000/80000000/0", h, l, z);
    end
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_negdivisor: hi=%h lo=%h required 00000001/fffffffd", h, l);
    end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] h, l; logic z, zf, gd, dn; int bc;
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, h, l, z, zf, bc, gd, dn);
    checks++;
    if (h !== 32'h0000_0064 || l !== 32'hFFFF_FFFF || z !== 1'b1) begin
      errors++; $display("FAIL divz: hi=%h lo=%h dbz=%b required 00000064/ffffffff/1", h, l, z);
    end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL divz_busy_len: got %0d required 32", bc); end
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divz_hold: dbz=%b in idle, required 1", div_by_zero); end
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, h, l, z, zf, bc, gd, dn);
    checks++;
    if (zf !== 1'b0) begin errors++; $display("FAIL divz_clear: dbz=%b after start, required 0", zf); end
    checks++;
    if (h !== 32'h0000_0002 || l !== 32'h0000_000E || z !== 1'b0) begin
      errors++; $display("FAIL divu: hi=%h lo=%h dbz=%b required 00000002/0000000e/0", h, l, z);
    end
  endtask

  task automatic test_moves;
    hi_we = 1'b1; lo_we = 1'b1; move_data = 32'hA5A5_A5A5;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL move_both: hi=%h lo=%h required a5a5a5a5/a5a5a5a5", hi, lo);
    end
    lo_we = 1'b1; move_data = 32'h0000_1234;
    @(negedge clock);
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0000_1234) begin
      errors++; $display("FAIL move_lo: hi=%h lo=%h required a5a5a5a5/00001234", hi, lo);
    end
  endtask

  task automatic test_ignore_during_run;
    bit gd;
    start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
    hi_we = 1'b1; move_data = 32'h1111_1111;
    @(posedge clock);
    #1 start = 1'b0; hi_we = 1'b0;
    @(negedge clock);
    checks++;
    if (hi !== 32'hA5A5_A5A5 || busy !== 1'b1) begin
      errors++; $display("FAIL start_wins: hi=%h busy=%b required a5a5a5a5/1", hi, busy);
    end
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; move_data = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0000_1234) begin
      errors++; $display("FAIL run_move_ignored: hi=%h lo=%h required a5a5a5a5/00001234", hi, lo);
    end
    gd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin gd = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!gd || hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL run_start_ignored: done=%b hi=%h lo=%h required 1/00000000/0000002a", gd, hi, lo);
    end
    hi_we = 1'b1; move_data = 32'h1234_5678;
    @(negedge clock);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'd42 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL done_move: hi=%h lo=%h busy=%b done=%b required 12345678/0000002a/0/0", hi, lo, busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] h, l; logic z, zf, gd, dn; int bc;
    start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
    end
    reset = 1'b0;
    run_op(2'b01, 32'd3, 32'd5, h, l, z, zf, bc, gd, dn);
    checks++;
    if (!gd || h !== 32'd0 || l !== 32'h0000_000F) begin
      errors++; $display("FAIL after_reset: done=%b hi=%h lo=%h required 1/00000000/0000000f", gd, h, l);
    end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL after_reset_busy_len: got %0d required 32", bc); end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_multu_max;
    test_mult_signed;
    test_div_signed;
    test_div_by_zero;
    test_moves;
    test_ignore_during_run;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request to begin an operation, sampled at the rising edge.
REQ-004 SHALL have ports: op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: rs_data  in  32  first operand (multiplicand / dividend), driven from the register-file ReadData1 port.
REQ-006 SHALL have ports: rt_data  in  32  second operand (multiplier / divisor), driven from the register-file ReadData2 port.
REQ-007 SHALL have ports: hi_we  in  1  MTHI write enable.
REQ-008 SHALL have ports: lo_we  in  1  MTLO write enable.
REQ-009 SHALL have ports: move_data  in  32  data for MTHI/MTLO.
REQ-010 SHALL have ports: hi  out  32  HI register.
REQ-011 SHALL have ports: lo  out  32  LO register.
REQ-012 SHALL have ports: busy  out  1  high while in RUN.
REQ-013 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-014 SHALL have ports: div_by_zero  out  1  set by a divide whose divisor is 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-016 SHALL accept start only in IDLE.
- On acceptance at edge E0: latch op, rs_data and rt_data; clear the 5-bit iteration counter; clear div_by_zero; enter RUN.
REQ-017 SHALL ignore start while in RUN or DONE; no queuing.
REQ-018 SHALL ignore rs_data/rt_data changes after E0; operands are held in internal registers.
REQ-019 SHALL perform one iteration per cycle in RUN.
- MULT/MULTU: radix-2 shift-add.
- DIV/DIVU: restoring division.
- Always exactly 32 iterations (edges E1..E32).
REQ-020 SHALL, at E32, write hi/lo with the final result and enter DONE; at E33, return to IDLE.
- done is high for exactly the cycle between E32 and E33.
- hi/lo are valid from E32 onward.
- Latency: start edge to done = 32 cycles.
REQ-021 SHALL, for signed ops (MULT, DIV), iterate on operand magnitudes and apply signs at E32.
- MULT: 64-bit two's-complement product.
- DIV quotient: negative iff operand signs differ.
- DIV remainder: takes the sign of the dividend.
REQ-022 SHALL place results as follows:
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder.
REQ-023 SHALL produce, for DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap, no flag.
REQ-024 SHALL handle divisor 0 (DIV or DIVU) as follows:
- Same 32-cycle latency.
- At E32: HI = dividend, LO = 0xFFFFFFFF, div_by_zero=1.
- div_by_zero holds until the next accepted start or reset.
REQ-025 SHALL apply hi_we/lo_we in IDLE and DONE only; ignored in RUN.
- hi_we and lo_we in the same cycle write both registers.
REQ-026 SHALL drop hi_we/lo_we asserted at the same edge as an accepted start (start wins).
REQ-027 SHALL apply hi_we/lo_we in DONE after the E32 result write, so a move issued in the DONE cycle overwrites the result.
REQ-028 SHALL keep hi/lo unchanged in IDLE absent hi_we/lo_we; hi/lo are not altered during RUN until E32.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, set state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-030 SHALL give reset priority over start, hi_we and lo_we.
REQ-031 SHALL discard any in-progress operation on reset with no write to hi/lo.
REQ-032 SHALL accept a start on the first edge after reset deasserts.

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, busy high for 32 cycles, done pulse exactly 1 cycle.
REQ-034 SHALL cover: MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 SHALL cover: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL cover: DIVU 0x00000064 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, div_by_zero=1, cleared by the next start.
REQ-037 SHALL cover: start pulse plus changed operands during RUN -> ignored, result from the original operands; hi_we during RUN -> hi unchanged; hi_we in DONE -> hi=move_data.
REQ-038 SHALL cover: reset asserted at iteration 10 -> next cycle busy=0, hi=lo=0; a new MULTU 3 x 5 then gives LO=0x0000000F, HI=0.
